// File: rtl/lr35902_oam_sweep.sv
// Sprite attribute memory with CPU, DMA and PPU ports plus a post-reset clear sweep.
// Storage is BPE byte-wide banks so the PPU fetches a whole entry in one cycle.
module lr35902_oam_sweep #(
    parameter int         ENTRIES   = 40,
    parameter int         BPE       = 4,
    parameter logic [7:0] CLEAR_VAL = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 cpu_adr,
    input  logic [7:0]                 cpu_din,
    input  logic                       cpu_read,
    input  logic                       cpu_write,
    output logic [7:0]                 cpu_dout,
    input  logic [7:0]                 dma_adr,
    input  logic [7:0]                 dma_din,
    input  logic                       dma_we,
    input  logic [$clog2(ENTRIES)-1:0] ppu_idx,
    input  logic                       ppu_read,
    output logic [BPE*8-1:0]           ppu_dout,
    input  logic                       lock,
    output logic                       busy
);
    localparam int IW    = $clog2(ENTRIES);
    localparam int LW    = $clog2(BPE);
    localparam int BYTES = ENTRIES * BPE;
    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    // reset_q and busy rely on flop power-up at 0 so the very first reset sweeps.
    logic          reset_q;
    logic          cpu_write_q;
    logic [IW-1:0] cnt;

    logic [IW-1:0] cpu_ent, dma_ent;
    logic [7:0]    cpu_lane, dma_lane;
    logic          cpu_oor, dma_oor, ppu_oor;
    logic          sweep_start, cpu_commit, dma_commit;

    logic          wr_en;
    logic [IW-1:0] wr_ent;
    logic [BPE-1:0] wr_mask;
    logic [7:0]    wr_data;

    logic [BPE-1:0][7:0] cpu_bytes;
    logic [BPE-1:0][7:0] ppu_word;
    logic [7:0]          cpu_byte;

    assign cpu_ent  = IW'(cpu_adr >> LW);
    assign dma_ent  = IW'(dma_adr >> LW);
    assign cpu_lane = cpu_adr & 8'(BPE - 1);
    assign dma_lane = dma_adr & 8'(BPE - 1);
    assign cpu_oor  = 32'(cpu_adr) >= BYTES;
    assign dma_oor  = 32'(dma_adr) >= BYTES;
    assign ppu_oor  = 32'(ppu_idx) >= ENTRIES;

    assign sweep_start = reset & ~reset_q;
    // The CPU strobe commits on its falling cycle; any DMA strobe that cycle wins the port.
    assign cpu_commit  = cpu_write_q & ~cpu_write & ~cpu_oor & ~lock & ~busy & ~dma_we;
    assign dma_commit  = dma_we & ~dma_oor & ~busy;

    always_comb begin
        wr_en   = 1'b0;
        wr_ent  = '0;
        wr_mask = '0;
        wr_data = CLEAR_VAL;
        if (busy) begin
            wr_en   = 1'b1;
            wr_ent  = cnt;
            wr_mask = '1;
        end else if (dma_commit) begin
            wr_en   = 1'b1;
            wr_ent  = dma_ent;
            wr_data = dma_din;
            for (int b = 0; b < BPE; b++) wr_mask[b] = (dma_lane == 8'(b));
        end else if (cpu_commit) begin
            wr_en   = 1'b1;
            wr_ent  = cpu_ent;
            wr_data = cpu_din;
            for (int b = 0; b < BPE; b++) wr_mask[b] = (cpu_lane == 8'(b));
        end
    end

    for (genvar b = 0; b < BPE; b++) begin : g_bank
        logic [7:0] bank [ENTRIES];

        always_ff @(posedge clk) begin
            if (wr_en && wr_mask[b]) bank[wr_ent] <= wr_data;
        end

        assign cpu_bytes[b] = bank[cpu_ent];
        assign ppu_word[b]  = bank[ppu_idx];
    end

    always_comb begin
        cpu_byte = 8'h00;
        for (int b = 0; b < BPE; b++) begin
            if (cpu_lane == 8'(b)) cpu_byte = cpu_bytes[b];
        end
    end

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (sweep_start) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            cnt <= cnt + IW'(1);
            if (cnt == LAST) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || busy) cpu_write_q <= 1'b0;
        else               cpu_write_q <= cpu_write;
    end

    // Read ports sample the banks before this edge's write lands, giving read-first data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout <= 8'h00;
            ppu_dout <= '0;
        end else begin
            if (cpu_read) cpu_dout <= (cpu_oor || lock || busy) ? 8'hFF : cpu_byte;
            if (ppu_read) ppu_dout <= ppu_oor ? '1 : ppu_word;
        end
    end
endmodule

// File: doc/lr35902_oam_sweep.md
LR35902_OAM_SWEEP -- requirements
Module: lr35902_oam_sweep

Interface
REQ-001 SHALL have parameter ENTRIES, default 40, meaning number of sprite entries.
REQ-002 SHALL have parameter BPE, default 4, meaning bytes per entry (power of two, 1..8); ENTRIES*BPE SHALL be <= 256.
REQ-003 SHALL have parameter CLEAR_VAL, default 8'h00, meaning byte value written by the clear sweep.
REQ-004 SHALL have ports: clk  in  1  system clock (all logic on rising edge).
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: cpu_adr in 8 byte address; cpu_din in 8 write data; cpu_read in 1 read enable; cpu_write in 1 write strobe; cpu_dout out 8 read data.
REQ-007 SHALL have ports: dma_adr in 8 byte address; dma_din in 8 data; dma_we in 1 immediate write strobe.
REQ-008 SHALL have ports: ppu_idx in $clog2(ENTRIES) entry index; ppu_read in 1; ppu_dout out BPE*8 whole entry, byte 0 in bits [7:0].
REQ-009 SHALL have ports: lock in 1 PPU owns memory; busy out 1 clear sweep active.

Function
REQ-010 Byte address a maps to entry a/BPE, byte lane a%BPE; a >= ENTRIES*BPE is out of range.
REQ-011 Storage SHALL be BPE byte-wide banks of ENTRIES words, so one entry is read whole in one cycle.
REQ-012 CPU read: when cpu_read=1, cpu_dout SHALL update on the next edge to the addressed byte; 8'hFF if out of range, lock=1 or busy=1; otherwise hold.
REQ-013 CPU write SHALL commit on the cycle cpu_write is sampled 0 after being 1 (falling strobe), using the cpu_adr/cpu_din present on that cycle.
REQ-014 CPU write SHALL be dropped if out of range, lock=1, busy=1 or dma_we=1 on the commit cycle.
REQ-015 DMA write SHALL commit on the edge where dma_we=1, ignoring lock; dropped if out of range or busy=1.
REQ-016 Write priority: clear sweep > DMA > CPU; exactly one write per cycle.
REQ-017 PPU read: when ppu_read=1, ppu_dout SHALL update on the next edge to the entry at ppu_idx (1-cycle latency), all-ones if ppu_idx >= ENTRIES; otherwise hold.
REQ-018 Read-during-write to the same location SHALL return old data (read-first) on both read ports.
REQ-019 Clear sweep: on an edge where reset=1 and previous-cycle reset=0, counter SHALL load 0 and busy SHALL go 1.
REQ-020 While busy=1, each edge SHALL write CLEAR_VAL to all BPE bytes of entry counter, then increment; at counter=ENTRIES-1 busy SHALL drop on that edge.
REQ-021 busy SHALL stay high for exactly ENTRIES cycles regardless of reset level; a new reset rising edge mid-sweep SHALL restart the counter at 0.
REQ-022 The previous-reset flop SHALL power up 0, so the first reset triggers a sweep.
REQ-023 The cpu_write edge-detect flop SHALL be forced 0 while reset=1 or busy=1, so no CPU write commits from a strobe straddling reset.

Reset
REQ-024 With reset=1: cpu_dout SHALL be 8'h00, ppu_dout SHALL be 0, the edge-detect flop 0; busy per REQ-019..021.
REQ-025 Memory contents SHALL be changed only by the sweep, never cleared directly by reset level.
REQ-026 Reads with reset=1 SHALL be ignored; outputs hold reset values until the first read after reset deasserts.

Verification
REQ-027 Sweep: preload entry 39 with 8'hAB, pulse reset 1 cycle -> busy high exactly 40 cycles; after it, CPU reads of adr 156..159 return 8'h00.
REQ-028 CPU write: cpu_adr=8'h05, cpu_din=8'h3C, cpu_write 1 for 2 cycles then 0 -> byte committed on the falling cycle only; ppu_idx=1 read returns 32'h00003C00.
REQ-029 Conflict: DMA writes 8'h11 to adr 8 on the same cycle a CPU write to adr 9 commits -> adr 8 = 8'h11, adr 9 unchanged.
REQ-030 Lock: lock=1, CPU write 8'h77 to adr 0 and CPU read -> cpu_dout 8'hFF, memory unchanged; DMA write 8'h77 to adr 0 under lock succeeds.
REQ-031 Bounds: CPU read of adr 160 returns 8'hFF; write to 160 leaves all 160 bytes unchanged; ppu_idx=40 returns 32'hFFFFFFFF.
REQ-032 Restart: reset rising at sweep cycle 20, again rising 1 cycle later after a 1-cycle low -> busy continuous, 40 cycles from the second rising edge.
